// File: rtl/vector_display_engine.sv
// rtl/vector_display_engine.sv - display-list driven X/Y vector beam engine
// Fetches MOVE/LINE/EOL words and steps the beam one point per clock-enable tick.
module vector_display_engine #(
  parameter int OUT_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int TICK_DIV    = 100,
  parameter int BLANK_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [ADDR_WIDTH-1:0]  addr,
  input  logic [2*OUT_WIDTH+1:0] data_in,
  output logic [OUT_WIDTH-1:0]   x_ch,
  output logic [OUT_WIDTH-1:0]   y_ch,
  output logic                   blank,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int EW = OUT_WIDTH + 2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MOVE, S_DRAW, S_EOL} state_t;
  state_t state, state_nx;

  logic [15:0]          tick_cnt;
  logic                 tick;
  logic                 w_pos, w_line;
  logic [OUT_WIDTH-1:0] w_x, w_y;
  logic [OUT_WIDTH-1:0] cur_x, cur_y, tgt_x, tgt_y;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic                 sx_neg, sy_neg;
  logic [15:0]          move_cnt;

  logic signed [EW-1:0] diff_x, diff_y, abs_dx, nabs_dy, err_nx;
  logic signed [EW:0]   e2;
  logic                 step_x, step_y, at_target, move_done, draw_done, prim_done;

  assign w_pos  = data_in[0];
  assign w_line = data_in[1];
  assign w_x    = data_in[OUT_WIDTH+1:2];
  assign w_y    = data_in[2*OUT_WIDTH+1:OUT_WIDTH+2];
  assign tick   = (tick_cnt == 16'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 16'd1;
  end

  // Minor-axis ties defer the y step, so shallow lines advance along x first.
  always_comb begin
    diff_x    = $signed({2'b00, w_x}) - $signed({2'b00, cur_x});
    diff_y    = $signed({2'b00, w_y}) - $signed({2'b00, cur_y});
    abs_dx    = diff_x[EW-1] ? -diff_x : diff_x;
    nabs_dy   = diff_y[EW-1] ? diff_y : -diff_y;
    e2        = {err_q, 1'b0};
    step_x    = (e2 >= dy_q);
    step_y    = (e2 < dx_q);
    err_nx    = err_q;
    if (step_x) err_nx = err_nx + dy_q;
    if (step_y) err_nx = err_nx + dx_q;
    at_target = (x_ch == tgt_x) && (y_ch == tgt_y);
    move_done = tick && (move_cnt == 16'(BLANK_TICKS - 1));
    draw_done = tick && at_target;
    prim_done = ((state == S_MOVE) && move_done) || ((state == S_DRAW) && draw_done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE:   if (enable) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = w_pos ? S_MOVE : (w_line ? S_DRAW : S_EOL);
      S_MOVE:   if (move_done) state_nx = enable ? S_FETCH : S_IDLE;
      S_DRAW:   if (draw_done) state_nx = enable ? S_FETCH : S_IDLE;
      S_EOL:    state_nx = enable ? S_FETCH : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      x_ch       <= '0;
      y_ch       <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      move_cnt   <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_DECODE: begin
          tgt_x    <= w_x;
          tgt_y    <= w_y;
          move_cnt <= '0;
          if (w_pos) begin
            x_ch <= w_x;
            y_ch <= w_y;
          end else if (w_line) begin
            x_ch   <= cur_x;
            y_ch   <= cur_y;
            blank  <= 1'b0;
            dx_q   <= abs_dx;
            dy_q   <= nabs_dy;
            err_q  <= abs_dx + nabs_dy;
            sx_neg <= diff_x[EW-1];
            sy_neg <= diff_y[EW-1];
          end else begin
            addr       <= '0;
            frame_done <= 1'b1;
          end
        end
        S_MOVE: if (tick) move_cnt <= move_cnt + 16'd1;
        S_DRAW: begin
          if (tick && !at_target) begin
            err_q <= err_nx;
            if (step_x) x_ch <= sx_neg ? x_ch - 1'b1 : x_ch + 1'b1;
            if (step_y) y_ch <= sy_neg ? y_ch - 1'b1 : y_ch + 1'b1;
          end
        end
        default: ;
      endcase
      if (prim_done) begin
        cur_x <= tgt_x;
        cur_y <= tgt_y;
        blank <= 1'b1;
        if (addr == '1) begin
          addr       <= '0;
          frame_done <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_display_engine.sv
// tb/tb_vector_display_engine.sv - directed self-checking bench for vector_display_engine
// Two instances: fast-tick main list, and a 2-bit-address slow-tick instance for wrap and reset.
module tb_vector_display_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en1 = 1'b0, en2 = 1'b0;
  logic [7:0]  addr1, x1, y1, x2, y2;
  logic [1:0]  addr2;
  logic [17:0] data1 = '0, data2 = '0;
  logic        blank1, busy1, fd1, blank2, busy2, fd2;
  logic [17:0] mem1 [256];
  logic [17:0] mem2 [4];
  int          checks = 0, errors = 0;
  int          px[$], py[$];

  always #5 clk = ~clk;

  vector_display_engine #(.OUT_WIDTH(8), .ADDR_WIDTH(8), .TICK_DIV(1), .BLANK_TICKS(4)) dut (
    .clk(clk), .rst(rst), .enable(en1), .addr(addr1), .data_in(data1),
    .x_ch(x1), .y_ch(y1), .blank(blank1), .busy(busy1), .frame_done(fd1));

  vector_display_engine #(.OUT_WIDTH(8), .ADDR_WIDTH(2), .TICK_DIV(100), .BLANK_TICKS(4)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .addr(addr2), .data_in(data2),
    .x_ch(x2), .y_ch(y2), .blank(blank2), .busy(busy2), .frame_done(fd2));

  always @(posedge clk) data1 <= mem1[addr1];
  always @(posedge clk) data2 <= mem2[addr2];

  function automatic logic [17:0] wd(input logic [7:0] x, input logic [7:0] y,
                                     input logic ln, input logic ps);
    return {y, x, ln, ps};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic move1(input int a, input int tx, input int ty, input string tag);
    int n = 0, guard = 0;
    while (!(addr1 == a && x1 == tx && y1 == ty) && guard < 100) begin cyc(); guard++; end
    chk({tag, "_seen"}, guard < 100, 1);
    while (addr1 == a && guard < 200) begin
      if (x1 == tx && y1 == ty && blank1) n++;
      cyc();
      guard++;
    end
    chk({tag, "_hold"}, n, 4);
  endtask

  task automatic line1(input int a, input int drop_at, input string tag);
    int guard = 0;
    px.delete();
    py.delete();
    while (blank1 && guard < 100) begin cyc(); guard++; end
    chk({tag, "_start"}, guard < 100, 1);
    while (!blank1 && guard < 400) begin
      px.push_back(int'(x1));
      py.push_back(int'(y1));
      if (px.size() == drop_at) en1 = 1'b0;
      cyc();
      guard++;
    end
    chk({tag, "_addr_next"}, addr1, a + 1);
  endtask

  initial begin
    int ex[5], ey[5];
    int ok, guard, maxa, seen;
    ex = '{10, 11, 12, 13, 14};
    ey = '{10, 10, 11, 11, 12};
    for (int i = 0; i < 256; i++) mem1[i] = '0;
    mem1[0] = wd(10, 10, 0, 1);
    mem1[1] = wd(14, 12, 1, 0);
    mem1[2] = wd(20, 20, 0, 1);
    mem1[3] = wd(18, 26, 1, 0);
    mem1[4] = wd(5, 5, 0, 1);
    mem1[5] = wd(5, 5, 1, 0);
    mem1[6] = wd(0, 0, 0, 1);
    mem1[7] = wd(99, 0, 1, 0);
    mem1[8] = wd(200, 100, 0, 1);
    mem1[9] = wd(0, 0, 0, 0);
    mem2[0] = wd(3, 0, 1, 0);
    mem2[1] = wd(3, 3, 1, 0);
    mem2[2] = wd(0, 3, 1, 0);
    mem2[3] = wd(0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr1, 0);
    chk("rst_x", x1, 0);
    chk("rst_y", y1, 0);
    chk("rst_blank", blank1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_frame_done", fd1, 0);
    @(negedge clk) rst = 1'b1;
    cyc();
    en1 = 1'b1;

    move1(0, 10, 10, "move_10_10");
    line1(1, -1, "line_14_12");
    chk("line_14_12_count", px.size(), 5);
    for (int i = 0; i < 5 && i < px.size(); i++)
      chk("line_14_12_point", px[i] * 256 + py[i], ex[i] * 256 + ey[i]);

    move1(2, 20, 20, "move_20_20");
    line1(3, -1, "steep");
    chk("steep_count", px.size(), 7);
    ok = 1;
    for (int i = 1; i < px.size(); i++) if (py[i] != py[i-1] + 1) ok = 0;
    chk("steep_y_monotonic", ok, 1);
    ok = 1;
    for (int i = 0; i < px.size(); i++) if (px[i] < 18 || px[i] > 20) ok = 0;
    chk("steep_x_range", ok, 1);
    if (px.size() > 0) chk("steep_last", px[px.size()-1] * 256 + py[py.size()-1], 18 * 256 + 26);

    move1(4, 5, 5, "move_5_5");
    line1(5, -1, "zero_len");
    chk("zero_len_count", px.size(), 1);
    if (px.size() > 0) chk("zero_len_point", px[0] * 256 + py[0], 5 * 256 + 5);

    move1(6, 0, 0, "move_0_0");
    line1(7, 50, "long");
    chk("long_count", px.size(), 100);
    if (px.size() > 0) chk("long_last", px[px.size()-1] * 256 + py[py.size()-1], 99 * 256);
    repeat (3) cyc();
    chk("stop_busy", busy1, 0);
    chk("stop_blank", blank1, 1);
    chk("stop_addr", addr1, 8);
    chk("stop_x_held", x1, 99);
    en1 = 1'b1;
    move1(8, 200, 100, "resume");

    guard = 0;
    while (!fd1 && guard < 20) begin cyc(); guard++; end
    chk("eol_pulse_seen", guard < 20, 1);
    chk("eol_addr", addr1, 0);
    en1 = 1'b0;
    cyc();
    chk("eol_pulse_width", fd1, 0);
    chk("eol_idle_busy", busy1, 0);

    en2 = 1'b1;
    guard = 0;
    maxa = 0;
    while (!fd2 && guard < 5000) begin
      if (addr2 > maxa) maxa = addr2;
      cyc();
      guard++;
    end
    chk("wrap_pulse_seen", guard < 5000, 1);
    chk("wrap_max_addr", maxa, 3);
    chk("wrap_addr", addr2, 0);
    chk("wrap_point", x2 * 256 + y2, 0);
    cyc();
    chk("wrap_pulse_width", fd2, 0);
    seen = 0;
    guard = 0;
    while (!(blank2 == 1'b0 && x2 == 8'd2) && guard < 1000) begin cyc(); guard++; end
    chk("mid_draw_reached", guard < 1000, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_x", x2, 0);
    chk("async_rst_y", y2, 0);
    chk("async_rst_blank", blank2, 1);
    chk("async_rst_busy", busy2, 0);
    chk("async_rst_addr", addr2, 0);
    chk("async_rst_frame_done", fd2, 0);
    @(negedge clk) rst = 1'b1;
    cyc();
    chk("restart_addr", addr2, 0);
    guard = 0;
    while (blank2 && guard < 500) begin cyc(); guard++; end
    chk("restart_draw_seen", guard < 500, 1);
    chk("restart_first_point", x2 * 256 + y2, 0);
    chk("restart_fetch_addr", addr2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
